// File: rtl/uart_conf_tx_if.sv
// uart_conf_tx_if: burst request, parameter block and serial/status lines
// between a host-side controller (master) and uart_conf_tx (slave).
interface uart_conf_tx_if #(
    parameter int unsigned DATA_BIT_CNT_MAX = 7,
    parameter int unsigned CONF_PAR_MAX     = 4
);
    logic                                                 start;
    logic [(CONF_PAR_MAX+1)*(DATA_BIT_CNT_MAX+1)-1:0]     conf_par;
    logic                                                 uart_tx;
    logic                                                 busy;
    logic                                                 done;

    modport master (
        output start,
        output conf_par,
        input  uart_tx,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  conf_par,
        output uart_tx,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_conf_tx.sv
// uart_conf_tx: serializes a snapshot of CONF_PAR_MAX+1 configuration bytes
// as back-to-back UART frames, highest index first, LSB first per byte.
// Optional feature macro: UART_CONF_TX_PARITY_EN adds one even-parity bit
// between the last data bit and the stop bit.
module uart_conf_tx #(
    parameter int unsigned BIT_CNT_MAX      = 104,
    parameter int unsigned DATA_BIT_CNT_MAX = 7,
    parameter int unsigned CONF_PAR_MAX     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_conf_tx_if.slave bus
);
    localparam int unsigned DW  = DATA_BIT_CNT_MAX + 1;
    localparam int unsigned NP  = CONF_PAR_MAX + 1;
    localparam int unsigned BCW = (BIT_CNT_MAX > 0)      ? $clog2(BIT_CNT_MAX + 1)      : 1;
    localparam int unsigned DCW = (DATA_BIT_CNT_MAX > 0) ? $clog2(DATA_BIT_CNT_MAX + 1) : 1;
    localparam int unsigned PCW = (CONF_PAR_MAX > 0)     ? $clog2(CONF_PAR_MAX + 1)     : 1;

`ifdef UART_CONF_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_n;
    logic [BCW-1:0]   bit_cnt, bit_cnt_n;
    logic [DCW-1:0]   data_cnt, data_cnt_n;
    logic [PCW-1:0]   par_cnt, par_cnt_n;
    logic [DW-1:0]    shift, shift_n;
    logic [NP*DW-1:0] snap, snap_n;
    logic             tx_r, tx_n;
    logic             busy_r, busy_n;
    logic             done_r, done_n;
    logic             bit_end;
    logic [DW-1:0]    par_next;
    int unsigned      next_idx;
`ifdef UART_CONF_TX_PARITY_EN
    logic [DW-1:0]    par_cur;
`endif

    assign bus.uart_tx = tx_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

    // State, counters, snapshot and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= BCW'(BIT_CNT_MAX);
            data_cnt <= DCW'(DATA_BIT_CNT_MAX);
            par_cnt  <= PCW'(CONF_PAR_MAX);
            shift    <= '0;
            snap     <= '0;
            tx_r     <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            data_cnt <= data_cnt_n;
            par_cnt  <= par_cnt_n;
            shift    <= shift_n;
            snap     <= snap_n;
            tx_r     <= tx_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
        end
    end

    // Next state plus next output values, so every output is a flop and the
    // line level changes on the same edge that the state does.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        data_cnt_n = data_cnt;
        par_cnt_n  = par_cnt;
        shift_n    = shift;
        snap_n     = snap;
        tx_n       = tx_r;
        busy_n     = busy_r;
        done_n     = 1'b0;
        bit_end    = (bit_cnt == '0);
        next_idx   = (par_cnt == '0) ? 0 : 32'(par_cnt) - 1;
        par_next   = snap[next_idx*DW +: DW];
`ifdef UART_CONF_TX_PARITY_EN
        par_cur    = snap[32'(par_cnt)*DW +: DW];
`endif

        if (state != IDLE) begin
            bit_cnt_n = bit_end ? BCW'(BIT_CNT_MAX) : bit_cnt - 1'b1;
        end

        case (state)
            IDLE: begin
                if (bus.start) begin
                    snap_n  = bus.conf_par;
                    shift_n = bus.conf_par[CONF_PAR_MAX*DW +: DW];
                    state_n = START;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    tx_n    = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = shift >> 1;
                    if (data_cnt == '0) begin
                        data_cnt_n = DCW'(DATA_BIT_CNT_MAX);
`ifdef UART_CONF_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = ^par_cur;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        data_cnt_n = data_cnt - 1'b1;
                        tx_n       = shift_n[0];
                    end
                end
            end
`ifdef UART_CONF_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (par_cnt != '0) begin
                        par_cnt_n = par_cnt - 1'b1;
                        shift_n   = par_next;
                        state_n   = START;
                        tx_n      = 1'b0;
                    end else begin
                        par_cnt_n  = PCW'(CONF_PAR_MAX);
                        data_cnt_n = DCW'(DATA_BIT_CNT_MAX);
                        state_n    = IDLE;
                        tx_n       = 1'b1;
                        busy_n     = 1'b0;
                        done_n     = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_conf_tx.sv
// tb_uart_conf_tx: directed bench for uart_conf_tx; decodes each burst at
// mid-bit sample points and checks bytes, framing and done timing.
module tb_uart_conf_tx;
    localparam int unsigned BITP = 105;
`ifdef UART_CONF_TX_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif
    localparam int unsigned BURST = 5 * FB * BITP;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   done_cnt;

    uart_conf_tx_if #(.DATA_BIT_CNT_MAX(7), .CONF_PAR_MAX(4)) bus ();

    uart_conf_tx #(
        .BIT_CNT_MAX(104),
        .DATA_BIT_CNT_MAX(7),
        .CONF_PAR_MAX(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Leaves the caller #1 after the edge that sampled start.
    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Called #1 after the start edge; walks the whole burst.
    task automatic decode_burst(input string tag, input logic [39:0] exp);
        logic [7:0] byte_v;
        logic [7:0] exp_b;
        int         waited;
        int         d0;
        d0     = done_cnt;
        waited = 0;
        check({tag, "_busy0"}, {63'd0, bus.busy}, 64'd1);
        check({tag, "_tx0"}, {63'd0, bus.uart_tx}, 64'd0);
        for (int f = 0; f < 5; f++) begin
            exp_b = exp[(4-f)*8 +: 8];
            for (int b = 0; b < int'(FB); b++) begin
                repeat ((f == 0 && b == 0) ? 53 : BITP) @(posedge clk);
                waited += (f == 0 && b == 0) ? 53 : BITP;
                #1;
                if (b == 0) check($sformatf("%s_f%0d_start", tag, f), {63'd0, bus.uart_tx}, 64'd0);
                else if (b <= 8) byte_v[b-1] = bus.uart_tx;
                else if (b == int'(FB) - 1) check($sformatf("%s_f%0d_stop", tag, f), {63'd0, bus.uart_tx}, 64'd1);
                else check($sformatf("%s_f%0d_par", tag, f), {63'd0, bus.uart_tx}, {63'd0, ^exp_b});
            end
            check($sformatf("%s_f%0d_byte", tag, f), {56'd0, byte_v}, {56'd0, exp_b});
        end
        repeat (int'(BURST) - 1 - waited) @(posedge clk);
        #1;
        check({tag, "_busy_pre"}, {62'd0, bus.busy, bus.done}, 64'h2);
        @(posedge clk);
        #1;
        check({tag, "_done_at_end"}, {61'd0, bus.busy, bus.done, bus.uart_tx}, 64'h3);
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, {63'd0, bus.done}, 64'd0);
        check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int bad;
        int d0;
        checks       = 0;
        errors       = 0;
        done_cnt     = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.conf_par = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", {61'd0, bus.uart_tx, bus.busy, bus.done}, 64'h4);
        rst_n = 1'b1;

        // Idle with start low.
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.uart_tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        check("idle_500", 64'(bad), 64'd0);

        // Main burst.
        bus.conf_par = 40'hA5_3C_0F_81_7E;
        pulse_start();
        decode_burst("b1", 40'hA5_3C_0F_81_7E);

        // Loopback-style pattern.
        bus.conf_par = 40'h01_02_03_04_05;
        pulse_start();
        decode_burst("b2", 40'h01_02_03_04_05);

        // Restart request and parameter change mid-burst are ignored.
        bus.conf_par = 40'hC3_5A_F0_0F_99;
        pulse_start();
        fork
            decode_burst("b3", 40'hC3_5A_F0_0F_99);
            begin
                repeat (2000) @(posedge clk);
                @(negedge clk);
                bus.start    = 1'b1;
                bus.conf_par = 40'h11_22_33_44_55;
                @(negedge clk);
                bus.start    = 1'b0;
            end
        join
        repeat (20) @(posedge clk);
        #1;
        check("b3_no_restart", {63'd0, bus.busy}, 64'd0);

        // Reset during third frame's data bits.
        bus.conf_par = 40'hDE_AD_BE_EF_42;
        pulse_start();
        d0 = done_cnt;
        repeat (2 * FB * BITP + 3 * BITP) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out", {61'd0, bus.uart_tx, bus.busy, bus.done}, 64'h4);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
        check("rst_mid_idle", {62'd0, bus.uart_tx, bus.busy}, 64'h2);
        pulse_start();
        decode_burst("b4", 40'hDE_AD_BE_EF_42);

`ifdef UART_CONF_TX_PARITY_EN
        bus.conf_par = 40'h07_03_07_03_07;
        pulse_start();
        decode_burst("par", 40'h07_03_07_03_07);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
